// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, one-entry fetch buffer and instruction
// register, with a variable-latency program-memory read handshake and stall generation.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       LoadIR,
  input  logic       IncPC,
  input  logic       LoadPC,
  input  logic       SelPC,
  input  logic [7:0] RegVal,
  output logic [7:0] MemAddr,
  output logic       MemRd,
  input  logic [7:0] MemData,
  input  logic       MemValid,
  output logic [3:0] Opcode,
  output logic [3:0] Imm,
  output logic [7:0] PC,
  output logic       Stall,
  output logic       Halted
);

  typedef enum logic [2:0] {S_EMPTY, S_REQ, S_FULL, S_WAITPC, S_HALT} state_t;

  state_t     state_q, state_d;
  logic       squash_q, squash_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] fb_q, fb_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       mem_rd_q, mem_rd_d;

  logic       halted;
  logic       pc_upd;
  logic       bypass;
  logic       ir_load;
  logic [7:0] ir_src;

  always_comb begin
    halted  = (state_q == S_HALT);
    pc_upd  = (LoadPC | IncPC) & ~halted;
    bypass  = (state_q == S_REQ) & ~squash_q & MemValid;
    Stall   = LoadIR & ~((state_q == S_FULL) | bypass);
    ir_load = LoadIR & ~Stall;
    ir_src  = bypass ? MemData : fb_q;

    pc_d = pc_q;
    if (!halted) begin
      if (LoadPC)     pc_d = SelPC ? RegVal : {4'h0, ir_q[3:0]};
      else if (IncPC) pc_d = pc_q + 8'd1;
    end

    state_d  = state_q;
    squash_d = squash_q;
    fb_d     = fb_q;
    ir_d     = ir_q;

    case (state_q)
      S_EMPTY: state_d = S_REQ;
      S_REQ: begin
        if (MemValid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_EMPTY;
          end else if (LoadIR) begin
            // Bypassed word belongs to the old PC; a same-edge PC change refetches.
            state_d = pc_upd ? S_EMPTY : S_WAITPC;
          end else if (pc_upd) begin
            state_d = S_EMPTY;
          end else begin
            fb_d    = MemData;
            state_d = S_FULL;
          end
        end else if (pc_upd) begin
          squash_d = 1'b1;
        end
      end
      S_FULL: begin
        if (LoadIR)      state_d = pc_upd ? S_EMPTY : S_WAITPC;
        else if (pc_upd) state_d = S_EMPTY;
      end
      S_WAITPC: if (pc_upd) state_d = S_REQ;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_EMPTY;
    endcase

    if (ir_load) begin
      ir_d = ir_src;
      if (ir_src[7:4] == HALT_OP) state_d = S_HALT;
    end

    // Address is captured only on REQ entry and held until the completion edge.
    mem_rd_d   = (state_d == S_REQ);
    mem_addr_d = (state_d == S_REQ && state_q != S_REQ) ? pc_d : mem_addr_q;
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q    <= S_EMPTY;
      squash_q   <= 1'b0;
      pc_q       <= RESET_PC;
      fb_q       <= 8'h00;
      ir_q       <= 8'h00;
      mem_addr_q <= 8'h00;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      pc_q       <= pc_d;
      fb_q       <= fb_d;
      ir_q       <= ir_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign MemAddr = mem_addr_q;
  assign MemRd   = mem_rd_q;
  assign Opcode  = ir_q[7:4];
  assign Imm     = ir_q[3:0];
  assign PC      = pc_q;
  assign Halted  = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized controller checked
// against an architectural model (PC arithmetic, IR = mem[PC] on each accepted load).
module tb_fetch_unit;
  logic       CLK = 1'b0;
  logic       CLB = 1'b0;
  logic       LoadIR = 1'b0, IncPC = 1'b0, LoadPC = 1'b0, SelPC = 1'b0;
  logic [7:0] RegVal = 8'h00;
  logic [7:0] MemAddr, MemData, PC;
  logic       MemRd, MemValid, Stall, Halted;
  logic [3:0] Opcode, Imm;

  logic [7:0] mem [256];
  int         wait_n = 0;
  int         cnt;
  logic       mv_force_en = 1'b0, mv_force_val = 1'b0;
  int         n_cmp = 0, n_err = 0;

  fetch_unit dut (
    .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
    .SelPC(SelPC), .RegVal(RegVal), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemData(MemData), .MemValid(MemValid), .Opcode(Opcode), .Imm(Imm),
    .PC(PC), .Stall(Stall), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  // Memory model: read completes wait_n cycles after MemRd rises.
  assign MemValid = mv_force_en ? mv_force_val : (MemRd && cnt >= wait_n);
  assign MemData  = mem[MemAddr];
  always @(posedge CLK or negedge CLB) begin
    if (!CLB)                  cnt <= 0;
    else if (MemRd && MemValid) cnt <= 0;
    else if (MemRd)            cnt <= cnt + 1;
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic ctl(input logic lir, input logic inc, input logic ldpc, input logic sel, input logic [7:0] rv);
    LoadIR = lir; IncPC = inc; LoadPC = ldpc; SelPC = sel; RegVal = rv;
  endtask

  task automatic do_reset();
    ctl(0, 0, 0, 0, 8'h00);
    mv_force_en = 1'b0;
    CLB = 1'b0;
    step(); step();
    CLB = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); wait_n = 4;
    step(); #3;
    n_cmp++; if (MemRd !== 1'b1) begin n_err++; $display("FAIL rst_pre_req: got %b want 1", MemRd); end
    step();
    mv_force_en = 1'b1; mv_force_val = 1'b1;
    #2 CLB = 1'b0; #1;
    n_cmp++; if (MemRd !== 1'b0) begin n_err++; $display("FAIL rst_memrd_async: got %b want 0", MemRd); end
    n_cmp++; if (PC !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", PC); end
    n_cmp++; if ({Opcode, Imm} !== 8'h00) begin n_err++; $display("FAIL rst_ir: got %h want 00", {Opcode, Imm}); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", Halted); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_idle: got %b want 0", Stall); end
    repeat (3) begin step(); mv_force_val = ~mv_force_val; end
    LoadIR = 1'b1; #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_lir: got %b want 1", Stall); end
    LoadIR = 1'b0;
    n_cmp++; if (MemRd !== 1'b0 || PC !== 8'h00) begin n_err++; $display("FAIL rst_hold: got rd=%b pc=%h want rd=0 pc=00", MemRd, PC); end
    mv_force_en = 1'b0; wait_n = 0;
    step(); CLB = 1'b1; #3;
    n_cmp++; if (MemRd !== 1'b0) begin n_err++; $display("FAIL rst_release_idle: got %b want 0", MemRd); end
    step(); #3;
    n_cmp++; if (MemRd !== 1'b1 || MemAddr !== 8'h00) begin n_err++; $display("FAIL rst_first_req: got rd=%b addr=%h want rd=1 addr=00", MemRd, MemAddr); end
  endtask

  task automatic test_zero_wait_stream();
    mem[8'h00] = 8'h13; mem[8'h01] = 8'h1A;
    do_reset(); wait_n = 0;
    step();
    ctl(1, 0, 0, 0, 8'h00); #3;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL zw_stall0: got %b want 0", Stall); end
    step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h13 || PC !== 8'h00) begin n_err++; $display("FAIL zw_ir0: got ir=%h pc=%h want ir=13 pc=00", {Opcode, Imm}, PC); end
    ctl(0, 1, 0, 0, 8'h00); step(); #3;
    n_cmp++; if (PC !== 8'h01 || MemRd !== 1'b1 || MemAddr !== 8'h01) begin n_err++; $display("FAIL zw_inc1: got pc=%h rd=%b addr=%h want 01 1 01", PC, MemRd, MemAddr); end
    ctl(1, 0, 0, 0, 8'h00); #3;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL zw_stall1: got %b want 0", Stall); end
    step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h1A) begin n_err++; $display("FAIL zw_ir1: got %h want 1a", {Opcode, Imm}); end
    ctl(0, 1, 0, 0, 8'h00); step(); #3;
    n_cmp++; if (PC !== 8'h02) begin n_err++; $display("FAIL zw_inc2: got %h want 02", PC); end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_wait3();
    mem[8'h00] = 8'h13;
    do_reset(); wait_n = 3;
    step();
    ctl(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #3;
      n_cmp++; if (Stall !== 1'b1 || {Opcode, Imm} !== 8'h00) begin n_err++; $display("FAIL w3_stall%0d: got stall=%b ir=%h want 1 00", k, Stall, {Opcode, Imm}); end
      step();
    end
    #3;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL w3_bypass: got %b want 0", Stall); end
    step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h13) begin n_err++; $display("FAIL w3_ir: got %h want 13", {Opcode, Imm}); end
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL w3_reload_stall: got %b want 1", Stall); end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_jumps();
    mem[8'h00] = 8'h2A; mem[8'h0A] = 8'h35; mem[8'hC4] = 8'h47;
    do_reset(); wait_n = 0;
    step();
    ctl(1, 0, 0, 0, 8'h00); step();
    ctl(0, 0, 1, 0, 8'h00); step(); #3;
    n_cmp++; if (PC !== 8'h0A || MemAddr !== 8'h0A || MemRd !== 1'b1) begin n_err++; $display("FAIL jmp_imm: got pc=%h addr=%h rd=%b want 0a 0a 1", PC, MemAddr, MemRd); end
    ctl(1, 0, 0, 0, 8'h00); step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h35) begin n_err++; $display("FAIL jmp_imm_ir: got %h want 35", {Opcode, Imm}); end
    ctl(0, 0, 1, 1, 8'hC4); step(); #3;
    n_cmp++; if (PC !== 8'hC4 || MemAddr !== 8'hC4) begin n_err++; $display("FAIL jmp_reg: got pc=%h addr=%h want c4 c4", PC, MemAddr); end
    ctl(1, 0, 0, 0, 8'h00); step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h47) begin n_err++; $display("FAIL jmp_reg_ir: got %h want 47", {Opcode, Imm}); end
    ctl(0, 1, 1, 0, 8'h00); step(); #3;
    n_cmp++; if (PC !== 8'h07) begin n_err++; $display("FAIL jmp_prio: got %h want 07", PC); end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_squash_wrap();
    mem[8'h00] = 8'h5E; mem[8'hFF] = 8'h22; mem[8'h30] = 8'h6B;
    do_reset(); wait_n = 0;
    step();
    ctl(1, 0, 0, 0, 8'h00); step();
    ctl(0, 0, 1, 1, 8'hFF); step();
    ctl(1, 0, 0, 0, 8'h00); step();
    wait_n = 2;
    ctl(0, 1, 0, 0, 8'h00); step(); #3;
    n_cmp++; if (PC !== 8'h00 || MemAddr !== 8'h00) begin n_err++; $display("FAIL wrap: got pc=%h addr=%h want 00 00", PC, MemAddr); end
    ctl(0, 0, 1, 1, 8'h30); step(); #3;
    n_cmp++; if (PC !== 8'h30 || MemAddr !== 8'h00 || MemRd !== 1'b1) begin n_err++; $display("FAIL sq_hold: got pc=%h addr=%h rd=%b want 30 00 1", PC, MemAddr, MemRd); end
    ctl(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      #3;
      n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL sq_stall%0d: got %b want 1", k, Stall); end
      step();
    end
    #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h22 || MemRd !== 1'b0 || Stall !== 1'b1) begin n_err++; $display("FAIL sq_discard: got ir=%h rd=%b stall=%b want 22 0 1", {Opcode, Imm}, MemRd, Stall); end
    step(); #3;
    n_cmp++; if (MemAddr !== 8'h30 || MemRd !== 1'b1) begin n_err++; $display("FAIL sq_reissue: got addr=%h rd=%b want 30 1", MemAddr, MemRd); end
    step(); step(); #3;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL sq_arrive: got %b want 0", Stall); end
    step(); #3;
    n_cmp++; if ({Opcode, Imm} !== 8'h6B) begin n_err++; $display("FAIL sq_ir: got %h want 6b", {Opcode, Imm}); end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_halt();
    mem[8'h00] = 8'h25; mem[8'h05] = 8'hF0;
    do_reset(); wait_n = 0;
    step();
    ctl(1, 0, 0, 0, 8'h00); step();
    ctl(0, 0, 1, 0, 8'h00); step();
    ctl(1, 1, 0, 0, 8'h00); step(); #3;
    n_cmp++; if (Halted !== 1'b1 || PC !== 8'h06 || Opcode !== 4'hF) begin n_err++; $display("FAIL halt_enter: got h=%b pc=%h op=%h want 1 06 f", Halted, PC, Opcode); end
    ctl(0, 1, 0, 0, 8'h00);
    repeat (3) step();
    ctl(0, 0, 1, 1, 8'hAA); step(); #3;
    n_cmp++; if (PC !== 8'h06 || MemRd !== 1'b0) begin n_err++; $display("FAIL halt_frozen: got pc=%h rd=%b want 06 0", PC, MemRd); end
    ctl(1, 0, 0, 0, 8'h00); #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL halt_stall: got %b want 1", Stall); end
    CLB = 1'b0; #1; CLB = 1'b1; #1;
    n_cmp++; if (Halted !== 1'b0 || PC !== 8'h00 || {Opcode, Imm} !== 8'h00 || MemRd !== 1'b0) begin n_err++; $display("FAIL halt_clear: got h=%b pc=%h ir=%h rd=%b want 0 00 00 0", Halted, PC, {Opcode, Imm}, MemRd); end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] pc_m, ir_m, pc_n, ir_n;
    logic       lir, inc, ldpc, sel, st;
    logic [7:0] rv;
    bit         loaded;
    int         phase, stall_run;
    for (int a = 0; a < 256; a++) mem[a] = {4'($urandom_range(0, 14)), 4'($urandom)};
    do_reset();
    pc_m = 8'h00; ir_m = 8'h00; loaded = 0; phase = 0; stall_run = 0;
    for (int c = 0; c < 600; c++) begin
      if (!MemRd) wait_n = $urandom_range(0, 3);
      lir = 0; inc = 0; ldpc = 0; sel = 0; rv = 8'($urandom);
      if (phase == 0) lir = 1;
      else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: inc = 1;
          5, 6, 7: begin ldpc = 1; sel = 1'($urandom); inc = 1'($urandom); end
          8: lir = loaded;
          default: ;
        endcase
      end
      ctl(lir, inc, ldpc, sel, rv); #3;
      st = Stall;
      n_cmp++; if (PC !== pc_m) begin n_err++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, PC, pc_m); end
      n_cmp++; if ({Opcode, Imm} !== ir_m) begin n_err++; $display("FAIL rnd_ir c=%0d: got %h want %h", c, {Opcode, Imm}, ir_m); end
      n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL rnd_halted c=%0d: got %b want 0", c, Halted); end
      if (!lir) begin
        n_cmp++; if (st !== 1'b0) begin n_err++; $display("FAIL rnd_stall_idle c=%0d: got %b want 0", c, st); end
      end else if (loaded) begin
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL rnd_stall_reload c=%0d: got %b want 1", c, st); end
      end
      if (lir && !st && MemRd && MemValid) begin
        n_cmp++; if (MemAddr !== pc_m) begin n_err++; $display("FAIL rnd_byp_addr c=%0d: got %h want %h", c, MemAddr, pc_m); end
      end
      if (phase == 0) begin
        stall_run = st ? stall_run + 1 : 0;
        n_cmp++; if (stall_run > 12) begin n_err++; $display("FAIL rnd_liveness c=%0d: stalled %0d cycles want <=12", c, stall_run); break; end
      end
      ir_n = ir_m; pc_n = pc_m;
      if (lir && !st) begin ir_n = mem[pc_m]; loaded = 1; end
      if (ldpc)     pc_n = sel ? rv : {4'h0, ir_m[3:0]};
      else if (inc) pc_n = pc_m + 8'd1;
      if (ldpc || inc) loaded = 0;
      ir_m = ir_n; pc_m = pc_n;
      if (phase == 0 && !st) phase = 1;
      else if (phase == 1 && (ldpc || inc)) phase = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step();
    end
    ctl(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_zero_wait_stream();
    test_wait3();
    test_jumps();
    test_squash_wrap();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
